// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg
//   Shared definitions for the booth multiplier share arbiter: sequencer
//   state encoding, default sizing and the product-width helper.
package booth_arb_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_W       = 8;
    localparam int DEF_TIMEOUT = 64;

    // Product of two W-bit signed operands needs 2*W bits.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    localparam int DEF_PW = prod_width(DEF_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first asserted request at or above
//   ptr, wrapping around.
//   Ports:
//     req   in  NREQ  request vector
//     ptr   in  IW    search start index (always < NREQ)
//     grant out NREQ  one-hot grant (zero when no request)
//     idx   out IW    encoded grant index (zero when no request)
//     any   out 1     at least one request present
module rr_arbiter
    import booth_arb_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                grant[(int'(ptr) + k) % NREQ] = 1'b1;
                idx = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/booth_share_arb.sv
// booth_share_arb
//   Shares one signed W x W booth multiplier between NREQ requesters.
//   One job in flight: accept (round-robin), pulse mul_start, wait for
//   mul_done, return the product on the granted requester's response channel.
//   Optional: define BOOTH_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT
//   cycles with rsp_data=0, rsp_err=1.
//   Ports:
//     clk, rst (sync, active low)
//     req_valid/req_ready/req_a/req_b   per-requester job channel
//     rsp_valid/rsp_ready/rsp_data/rsp_err  per-requester response channel
//     grant_idx, busy                   status
//     mul_start/mul_a/mul_b/mul_done/mul_r  multiplier interface
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_IDLE  | arbitrate; latch operands of the granted requester
//   ST_ISSUE | one-cycle mul_start
//   ST_WAIT  | wait for mul_done (first cycle blanked)
//   ST_RESP  | hold response until the granted requester takes it
module booth_share_arb
    import booth_arb_pkg::*;
#(
    parameter  int NREQ    = DEF_NREQ,
    parameter  int W       = DEF_W,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int PW      = prod_width(W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [PW-1:0]     rsp_data,
    output logic              rsp_err,
    output logic [IW-1:0]     grant_idx,
    output logic              busy,
    output logic              mul_start,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic              mul_done,
    input  logic [PW-1:0]     mul_r
);

    if (NREQ < 2 || TIMEOUT < 2) begin : g_param_chk
        $error("booth_share_arb: NREQ and TIMEOUT must be >= 2");
    end

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic [PW-1:0]     res_q, res_d;
    logic              start_q, start_d;
    logic              blank_q, blank_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              err_q, err_d;
`endif

    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic [NREQ-1:0]   gnt_onehot;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign gnt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << gidx_q;

    // Gated by rst so nothing is reported as accepted on a reset edge.
    assign req_ready = (state_q == ST_IDLE && rst) ? arb_grant : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        start_d     = 1'b0;
        blank_d     = blank_q;
        rsp_valid_d = rsp_valid_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
        tmr_d       = tmr_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gidx_d  = arb_idx;
                    a_d     = req_a[arb_idx*W +: W];
                    b_d     = req_b[arb_idx*W +: W];
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                blank_d = 1'b1;
`ifdef BOOTH_ARB_TIMEOUT_EN
                tmr_d   = TW'(TIMEOUT - 1);
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // mul_done may still be high from the previous job during
                // the first WAIT cycle, so it is not trusted there.
                blank_d = 1'b0;
                if (!blank_q && mul_done) begin
                    res_d       = mul_r;
                    rsp_valid_d = gnt_onehot;
                    state_d     = ST_RESP;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
                end else if (tmr_q == '0) begin
                    res_d       = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = gnt_onehot;
                    state_d     = ST_RESP;
                end else begin
                    tmr_d       = tmr_q - 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready[gidx_q]) begin
                    rsp_valid_d = '0;
                    ptr_d       = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            start_q     <= 1'b0;
            blank_q     <= 1'b0;
            rsp_valid_q <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            tmr_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            start_q     <= start_d;
            blank_q     <= blank_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
            tmr_q       <= tmr_d;
            err_q       <= err_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mul_start = start_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = res_q;
    assign grant_idx = gidx_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_booth_share_arb.sv
// tb_booth_share_arb
//   Self-checking bench for booth_share_arb with a behavioural multiplier
//   (3-cycle latency, done held high until the next start so a stale done
//   is visible in the first WAIT cycle). Expected responses are queued as
//   jobs are presented and checked in order as responses are taken.
module tb_booth_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int PW   = 16;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready = '0;
    logic [PW-1:0]     rsp_data;
    logic              rsp_err;
    logic [1:0]        grant_idx;
    logic              busy;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_done;
    logic [PW-1:0]     mul_r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    booth_share_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .grant_idx (grant_idx),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_r     (mul_r)
    );

    function automatic logic [15:0] sprod(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sbv;
        sa  = $signed(a);
        sbv = $signed(b);
        return sa * sbv;
    endfunction

    // Behavioural multiplier.
    bit         mul_hang = 1'b0;
    logic       m_run;
    int         m_cnt;
    logic [7:0] ma, mb;
    int         start_cnt = 0;

    always @(posedge clk) begin
        if (!rst) begin
            mul_done <= 1'b0;
            mul_r    <= '0;
            m_run    <= 1'b0;
            m_cnt    <= 0;
        end else if (mul_start) begin
            ma <= mul_a;
            mb <= mul_b;
            if (mul_hang) begin
                m_run    <= 1'b0;
                mul_done <= 1'b0;
            end else begin
                m_run <= 1'b1;
                m_cnt <= 3;
            end
        end else if (m_run) begin
            if (m_cnt == 1) begin
                mul_done <= 1'b1;
                mul_r    <= sprod(ma, mb);
                m_run    <= 1'b0;
            end else begin
                mul_done <= 1'b0;
                m_cnt    <= m_cnt - 1;
            end
        end
    end

    always @(posedge clk) if (rst && mul_start) start_cnt <= start_cnt + 1;

    task automatic step();
        logic [NREQ-1:0] acc;
        #1;
        acc = req_valid & req_ready;
        @(posedge clk);
        @(negedge clk);
        req_valid = req_valid & ~acc;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic push_exp(input int i, input logic [15:0] d, input logic e);
        exp_t x;
        x.idx  = i;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic drain(input int n, input string name, input int budget);
        int   got;
        exp_t e;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            #1;
            if ((rsp_valid & rsp_ready) != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected response rsp_valid=%b", name, rsp_valid);
                end else begin
                    e = sb.pop_front();
                    if (rsp_valid !== (4'b0001 << e.idx) || grant_idx !== 2'(e.idx)) begin
                        errors++;
                        $display("FAIL %s grant rsp_valid=%b grant_idx=%0d want idx %0d",
                                 name, rsp_valid, grant_idx, e.idx);
                    end
                    checks++;
                    if (rsp_data !== e.data) begin
                        errors++;
                        $display("FAIL %s data got=%h want=%h", name, rsp_data, e.data);
                    end
                    checks++;
                    if (rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL %s err got=%b want=%b", name, rsp_err, e.err);
                    end
                end
                got++;
            end
            step();
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s response count got=%0d want=%0d", name, got, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || mul_start !== 1'b0) begin
            errors++;
            $display("FAIL reset busy=%b mul_start=%b want 0 0", busy, mul_start);
        end
        checks++;
        if (rsp_valid !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset rsp_valid=%b req_ready=%b want 0", rsp_valid, req_ready);
        end
        checks++;
        if (grant_idx !== '0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset grant_idx=%0d rsp_data=%h rsp_err=%b want 0", grant_idx, rsp_data, rsp_err);
        end
        checks++;
        if (mul_a !== '0 || mul_b !== '0) begin
            errors++;
            $display("FAIL reset mul_a=%h mul_b=%h want 0", mul_a, mul_b);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        int s0;
        s0 = start_cnt;
        set_op(0, 8'd3, 8'd5);
        push_exp(0, 16'd15, 1'b0);
        rsp_ready = 4'hF;
        req_valid[0] = 1'b1;
        drain(1, "single", 40);
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL single mul_start pulses got=%0d want=1", start_cnt - s0);
        end
    endtask

    task automatic test_signed();
        set_op(1, 8'hFD, 8'h07);
        push_exp(1, 16'hFFEB, 1'b0);
        req_valid[1] = 1'b1;
        drain(1, "signed", 40);
    endtask

    task automatic test_contention();
        rst = 1'b0;
        set_op(0, 8'd1, 8'd2);
        set_op(1, 8'h80, 8'h80);
        set_op(2, 8'h7F, 8'hFF);
        set_op(3, 8'h05, 8'hF6);
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        push_exp(0, 16'd2, 1'b0);
        push_exp(1, 16'h4000, 1'b0);
        push_exp(2, 16'hFF81, 1'b0);
        push_exp(3, 16'hFFCE, 1'b0);
        drain(4, "contention_all", 150);
        set_op(0, 8'd11, 8'd13);
        set_op(2, 8'hF0, 8'h10);
        push_exp(0, sprod(8'd11, 8'd13), 1'b0);
        push_exp(2, sprod(8'hF0, 8'h10), 1'b0);
        req_valid = 4'b0101;
        drain(2, "contention_0_2", 80);
    endtask

    task automatic test_backpressure();
        rsp_ready = '0;
        set_op(2, 8'd10, 8'hFC);
        push_exp(2, 16'hFFD8, 1'b0);
        req_valid[2] = 1'b1;
        for (int c = 0; c < 40 && rsp_valid == '0; c++) step();
        checks++;
        if (rsp_valid == '0) begin
            errors++;
            $display("FAIL backpressure no rsp_valid within 40 cycles");
        end
        set_op(3, 8'd7, 8'd7);
        push_exp(3, 16'd49, 1'b0);
        req_valid[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 4'b0100 || rsp_data !== 16'hFFD8) begin
                errors++;
                $display("FAIL backpressure hold rsp_valid=%b rsp_data=%h want 0100 ffd8", rsp_valid, rsp_data);
            end
            checks++;
            if (req_ready !== '0 || mul_start !== 1'b0) begin
                errors++;
                $display("FAIL backpressure quiet req_ready=%b mul_start=%b want 0 0", req_ready, mul_start);
            end
            step();
        end
        rsp_ready = 4'hF;
        drain(2, "backpressure", 60);
    endtask

    task automatic test_reset_mid_wait();
        set_op(1, 8'd2, 8'd3);
        push_exp(1, 16'd6, 1'b0);
        req_valid[1] = 1'b1;
        drain(1, "pre_reset", 40);
        mul_hang = 1'b1;
        set_op(2, 8'd9, 8'd9);
        req_valid[2] = 1'b1;
        for (int c = 0; c < 20 && !mul_start; c++) step();
        checks++;
        if (mul_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_wait no mul_start within 20 cycles");
        end
        step();
        step();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mul_hang = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || mul_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait state busy=%b rsp_valid=%b mul_start=%b want 0", busy, rsp_valid, mul_start);
        end
        checks++;
        if (grant_idx !== '0 || rsp_data !== '0 || mul_a !== '0 || mul_b !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait regs grant_idx=%0d rsp_data=%h mul_a=%h mul_b=%h want 0",
                     grant_idx, rsp_data, mul_a, mul_b);
        end
        // Pointer back at 0: requester 1 must win over 3.
        set_op(1, 8'hFF, 8'hFF);
        set_op(3, 8'd20, 8'hEC);
        push_exp(1, 16'd1, 1'b0);
        push_exp(3, sprod(8'd20, 8'hEC), 1'b0);
        req_valid = 4'b1010;
        drain(2, "after_reset", 80);
    endtask

`ifdef BOOTH_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        mul_hang = 1'b1;
        set_op(0, 8'd5, 8'd5);
        push_exp(0, 16'd0, 1'b1);
        req_valid[0] = 1'b1;
        for (int c = 0; c < 20 && !mul_start; c++) step();
        checks++;
        if (mul_start !== 1'b1) begin
            errors++;
            $display("FAIL timeout no mul_start within 20 cycles");
        end
        n = 0;
        for (int c = 0; c < 40 && rsp_valid == '0; c++) begin
            step();
            n++;
        end
        checks++;
        if (n != TMO + 1) begin
            errors++;
            $display("FAIL timeout wait length got=%0d want=%0d", n, TMO + 1);
        end
        drain(1, "timeout_rsp", 10);
        mul_hang = 1'b0;
        set_op(1, 8'd6, 8'd7);
        push_exp(1, 16'd42, 1'b0);
        req_valid[1] = 1'b1;
        drain(1, "after_timeout", 40);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_signed();
        test_contention();
        test_backpressure();
        test_reset_mid_wait();
`ifdef BOOTH_ARB_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover expected responses count=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_share_arb.md
Name: booth_share_arb

Overview:
Round-robin arbiter and sequencer that shares one signed 8x8 booth multiplier between NREQ requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. The block accepts one job, pulses the multiplier's start, waits for done, and returns the 16-bit product to the granted requester. It sits between the client blocks and a single `booth` instance. Only one job is in flight at a time.

Parameters:
NREQ, 4, number of requesters (min 2).
W, 8, operand width; product width is 2*W.
TIMEOUT, 64, WAIT-state cycle limit (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset (rst==0 resets on clk rising edge)
req_valid  in  NREQ  per-requester job valid
req_ready  out  NREQ  per-requester job accept (one-hot or zero)
req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
req_b  in  NREQ*W  operand B, same packing
rsp_valid  out  NREQ  per-requester result valid (one-hot or zero)
rsp_ready  in  NREQ  per-requester result accept
rsp_data  out  2*W  product, shared bus, qualified by rsp_valid
rsp_err  out  1  timeout flag qualified by rsp_valid; tied 0 without the feature
grant_idx  out  $clog2(NREQ)  index of current/last granted requester
busy  out  1  high in any state except IDLE
mul_start  out  1  start pulse to multiplier
mul_a  out  W  operand A to multiplier
mul_b  out  W  operand B to multiplier
mul_done  in  1  multiplier done (level)
mul_r  in  2*W  multiplier product

Behaviour:
- Reset (rst==0): state IDLE, rr pointer 0, grant_idx 0, all outputs 0, operand/result registers 0. Reset mid-operation aborts the job with no response. The multiplier shares rst.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = first i with req_valid[i], searching from the rr pointer upward with wrap.
  - req_ready[grant] = 1 combinationally, in the same cycle only. A/B and the grant index are latched on that edge. Next state ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE: mul_start = 1 for exactly one cycle. mul_a/mul_b are driven from the latches and held stable through WAIT. Next state WAIT.
- WAIT:
  - mul_done is ignored in the first WAIT cycle (stale-done blanking).
  - From the second WAIT cycle, mul_done==1 captures mul_r into the result register. Next state RESP.
- RESP:
  - rsp_valid[grant] = 1; rsp_data = the result register, stable until handshake.
  - On rsp_ready[grant]: rr pointer = (grant+1) mod NREQ, next state IDLE.
  - rsp_ready of other requesters is ignored.
- Latency: accept at cycle T, mul_start at T+1, rsp_valid earliest at T+4. Actual latency = T+3+(multiplier cycles).
- Back-to-back jobs: at least one IDLE cycle between a response handshake and the next accept.
- Protocol rule: a requester holds req_valid and its operands until req_ready. The arbiter need not handle a dropped valid.
- Products are signed two's complement; rsp_data passes mul_r unmodified.
- Responses are never reordered; only one job is outstanding at a time.

Optional Feature:
BOOTH_ARB_TIMEOUT_EN:
- Defined: a WAIT-cycle counter saturates at TIMEOUT. On reaching TIMEOUT without a valid mul_done, the block enters RESP with rsp_data=0 and rsp_err=1. A subsequent good response clears rsp_err to 0.
- Undefined: no counter; WAIT lasts indefinitely; rsp_err is constant 0.

Decomposition:
- Package booth_arb_pkg:
  - state enum typedef (IDLE, ISSUE, WAIT, RESP)
  - default W/NREQ localparams
  - product-width helper constant
- Sub-module rr_arbiter (NREQ): inputs req vector and pointer; outputs one-hot grant and encoded index; combinational. Instantiated once.

Test Plan:
- Single job: req 0, A=8'd3, B=8'd5, rsp_ready=1 -> rsp_valid[0] with rsp_data=16'd15; mul_start pulses exactly once.
- Signed job: req 1, A=8'hFD (-3), B=8'h07 -> rsp_data=16'hFFEB on rsp_valid[1] only.
- Contention: all 4 requesters valid from reset -> grants in order 0,1,2,3. Then requesters 0 and 2 valid with pointer at 0 -> 0 then 2. grant_idx matches each response.
- Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_data stable; no req_ready asserted; no mul_start.
- Reset mid-WAIT: rst=0 for one cycle -> next cycle all outputs 0, busy=0, pointer 0; a new job then completes correctly.
- Timeout (BOOTH_ARB_TIMEOUT_EN, TIMEOUT=16): mul_done held 0 -> RESP after 16 WAIT cycles with rsp_err=1, rsp_data=0. The next good job returns rsp_err=0.
